spi_master: RTL and testbench

SPI master that drives the single-clock SPI slave protocol used by the SPI-with-RAM design: it serialises 10-bit command/data frames onto MOSI and, for read-data commands, shifts a returned byte in from MISO. It sits between a parallel host/sequencer and the `ss_n`/`MOSI`/`MISO` pins of the SPI slave. It serves as the stimulus side in system-level benches and as the RTL master in the integrated top.

---
 rtl/spi_master_pkg.sv | 17 +
 rtl/spi_master_if.sv | 19 +
 rtl/spi_master_shifter.sv | 32 +++
 rtl/spi_master.sv | 123 ++++++++++++
 tb/tb_spi_master.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/spi_master_pkg.sv
// Shared constants for the SPI master and the slave-side benches.
package spi_master_pkg;
  localparam int FRAME_W = 10;
  localparam int BYTE_W  = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_CMD   = 3'd1;
  localparam state_t S_SHIFT = 3'd2;
  localparam state_t S_GAP   = 3'd3;
  localparam state_t S_READ  = 3'd4;
endpackage

// File: rtl/spi_master_if.sv
// Host handshake plus SPI pins of the master; master = the spi_master view.
interface spi_master_if;
  import spi_master_pkg::*;
  logic              start;
  logic [1:0]        cmd;
  logic [BYTE_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic [BYTE_W-1:0] rd_data;
  logic              rd_valid;
  logic              ss_n;
  logic              MOSI;
  logic              MISO;

  modport master (input start, cmd, wdata, MISO,
                  output busy, done, rd_data, rd_valid, ss_n, MOSI);
  modport slave  (output start, cmd, wdata, MISO,
                  input busy, done, rd_data, rd_valid, ss_n, MOSI);
endinterface

// File: rtl/spi_master_shifter.sv
// MSB-first 10-bit shift-out register and shift-in register for the read byte.
module spi_master_shifter
  import spi_master_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               shift_i,
  input  logic               capture_i,
  input  logic [FRAME_W-1:0] frame_i,
  input  logic               miso_i,
  output logic               sout_o,
  output logic [BYTE_W-1:0]  byte_o
);
  logic [FRAME_W-1:0] so_q;
  // Only 7 bits are stored: the 8th sample goes straight into the result byte.
  logic [BYTE_W-2:0]  si_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      so_q <= '0;
      si_q <= '0;
    end else begin
      if (load_i)       so_q <= frame_i;
      else if (shift_i) so_q <= {so_q[FRAME_W-2:0], 1'b0};
      if (capture_i)    si_q <= {si_q[BYTE_W-3:0], miso_i};
    end
  end

  assign sout_o = so_q[FRAME_W-1];
  assign byte_o = {si_q, miso_i};
endmodule

// File: rtl/spi_master.sv
// SPI master: sends 10-bit {cmd,wdata} frames, reads a byte back on read-data.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int RD_GAP = 2
) (
  input  logic         clk,
  input  logic         rst,
  spi_master_if.master bus
);
  localparam logic [3:0] GAP_LOAD = 4'(RD_GAP - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              is_rd_q, is_rd_d;
  logic              done_q, done_d;
  logic              rv_q, rv_d;
  logic [BYTE_W-1:0] rdata_q, rdata_d;
  logic              load, shift, capture, sout;
  logic [BYTE_W-1:0] sbyte;

  spi_master_shifter u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .shift_i  (shift),
    .capture_i(capture),
    .frame_i  ({bus.cmd, bus.wdata}),
    .miso_i   (bus.MISO),
    .sout_o   (sout),
    .byte_o   (sbyte)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_rd_d = is_rd_q;
    done_d  = 1'b0;
    rv_d    = 1'b0;
    rdata_d = rdata_q;
    load    = 1'b0;
    shift   = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start) begin
        load    = 1'b1;
        is_rd_d = (bus.cmd == CMD_RD_DATA);
        cnt_d   = '0;
        state_d = S_CMD;
      end
      S_CMD: begin
        state_d = S_SHIFT;
        cnt_d   = 4'd10;
      end
      // frame[9] is already on the wire, so 9 shifts cover the rest; the
      // last count holds frame[0] for a second cycle.
      S_SHIFT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
          shift = (cnt_q >= 4'd2);
        end else if (is_rd_q) begin
          if (RD_GAP == 1) begin
            state_d = S_READ;
            cnt_d   = 4'd8;
          end else begin
            state_d = S_GAP;
            cnt_d   = GAP_LOAD;
          end
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == 4'd1) begin
          state_d = S_READ;
          cnt_d   = 4'd8;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_READ: begin
        capture = 1'b1;
        if (cnt_q == 4'd1) begin
          rdata_d = sbyte;
          rv_d    = 1'b1;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      is_rd_q <= 1'b0;
      done_q  <= 1'b0;
      rv_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_rd_q <= is_rd_d;
      done_q  <= done_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
    end
  end

  // Pins decode from registered state so reset forces them at once.
  assign bus.ss_n     = (state_q == S_IDLE);
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.MOSI     = ((state_q == S_CMD) || (state_q == S_SHIFT)) & sout;
  assign bus.done     = done_q;
  assign bus.rd_valid = rv_q;
  assign bus.rd_data  = rdata_q;
endmodule

// File: tb/tb_spi_master.sv
// Two masters (RD_GAP 2 and 4) on shared host inputs, checked against a cycle-index model.
module tb_spi_master;
  import spi_master_pkg::*;

  logic       clk, rst, start;
  logic [1:0] cmd;
  logic [7:0] wdata;
  logic       miso [2];
  int         vecs = 0, errs = 0;
  bit         force_en = 0;
  logic [7:0] force_val = 8'h00;

  spi_master_if b0();
  spi_master_if b1();
  assign b0.start = start; assign b0.cmd = cmd; assign b0.wdata = wdata; assign b0.MISO = miso[0];
  assign b1.start = start; assign b1.cmd = cmd; assign b1.wdata = wdata; assign b1.MISO = miso[1];

  spi_master #(.RD_GAP(2)) u0 (.clk(clk), .rst(rst), .bus(b0));
  spi_master #(.RD_GAP(4)) u1 (.clk(clk), .rst(rst), .bus(b1));

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  // Model: k = posedges since accept; everything follows from k and the frame.
  bit         act [2]    = '{0, 0};
  int         k [2]      = '{0, 0};
  logic [9:0] fr [2]     = '{10'h0, 10'h0};
  logic [7:0] rb [2]     = '{8'h0, 8'h0};
  logic [7:0] exp_rd [2] = '{8'h0, 8'h0};
  logic [12:0] got [2];
  assign got[0] = {b0.ss_n, b0.MOSI, b0.busy, b0.done, b0.rd_valid, b0.rd_data};
  assign got[1] = {b1.ss_n, b1.MOSI, b1.busy, b1.done, b1.rd_valid, b1.rd_data};

  function automatic int gap(int d); return (d == 0) ? 2 : 4; endfunction
  function automatic bit is_rd(int d); return fr[d][9:8] == CMD_RD_DATA; endfunction
  function automatic int flen(int d); return is_rd(d) ? 19 + gap(d) : 12; endfunction

  function automatic logic [12:0] expv(int d);
    logic ss, mo, bz, dn, rv;
    ss = 1'b1; mo = 1'b0; bz = 1'b0; dn = 1'b0; rv = 1'b0;
    if (act[d] && k[d] < flen(d)) begin
      ss = 1'b0; bz = 1'b1;
      if (k[d] == 0)       mo = fr[d][9];
      else if (k[d] <= 10) mo = fr[d][10 - k[d]];
      else if (k[d] == 11) mo = fr[d][0];
    end else if (act[d]) begin
      dn = 1'b1; rv = is_rd(d);
    end
    return {ss, mo, bz, dn, rv, exp_rd[d]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin act[d] <= 0; k[d] <= 0; exp_rd[d] <= 8'h00; end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (act[d] && k[d] < flen(d)) begin
          k[d] <= k[d] + 1;
          if (k[d] + 1 == flen(d) && is_rd(d)) exp_rd[d] <= rb[d];
        end else if (start) begin
          act[d] <= 1; k[d] <= 0; fr[d] <= {cmd, wdata};
          rb[d] <= force_en ? force_val : 8'($urandom);
        end else begin
          act[d] <= 0;
        end
      end
    end
  end

  // Slave side: the model's byte MSB-first in the read window, noise elsewhere.
  initial begin
    miso[0] = 1'b0; miso[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        int nk;
        nk = k[d] + 1;
        if (act[d] && is_rd(d) && k[d] < flen(d) && nk >= 12 + gap(d) && nk <= 19 + gap(d))
          miso[d] = rb[d][19 + gap(d) - nk];
        else
          miso[d] = 1'($urandom);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        logic [12:0] e;
        e = expv(d);
        vecs++;
        if (got[d] !== e) begin
          errs++;
          if (errs < 20)
            $display("FAIL dut%0d outputs t=%0t got ss,mosi,busy,done,rv,rd=%b expected %b",
                     d, $time, got[d], e);
        end
      end
    end
  end

  task automatic chk(input string nm, input int g, input int e);
    vecs++;
    if (g != e) begin
      errs++;
      $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", nm, g, g, e, e);
    end
  endtask

  // Issue one frame from idle and record dut0 MOSI/ss_n plus done indices.
  task automatic run_one(input logic [1:0] c, input logic [7:0] w, input int intr,
                         output int d0, output int d1, output logic [10:0] mseq,
                         output int sslow, output int ndone, output int nrv);
    d0 = -1; d1 = -1; mseq = '0; sslow = 0; ndone = 0; nrv = 0;
    @(negedge clk); start = 1'b1; cmd = c; wdata = w;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (i == 0) begin start = 1'b0; cmd = 2'($urandom); wdata = 8'($urandom); end
      if (i == intr) begin start = 1'b1; cmd = CMD_WR_DATA; wdata = 8'hFF; end
      if (i == intr + 1) start = 1'b0;
      if (i <= 10) mseq[10 - i] = b0.MOSI;
      if (!b0.ss_n) sslow++;
      if (b0.done) begin ndone++; if (d0 < 0) d0 = i; end
      if (b0.rd_valid) nrv++;
      if (b1.done && d1 < 0) d1 = i;
      if (d0 >= 0 && d1 >= 0 && i >= d0 + 3 && i >= d1 + 3) break;
    end
    if (d0 < 0 || d1 < 0) chk("frame_timeout", 0, 1);
  endtask

  initial begin
    int d0, d1, sslow, ndone, nrv, hrun, gaps;
    logic [10:0] mseq;
    bit seen_low;
    rst = 1'b1; start = 1'b0; cmd = 2'b00; wdata = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_dut0", int'(got[0]), int'(13'b1_0_0_0_0_00000000));
    chk("reset_dut1", int'(got[1]), int'(13'b1_0_0_0_0_00000000));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_one(CMD_WR_ADDR, 8'hA5, -1, d0, d1, mseq, sslow, ndone, nrv);
    chk("wa_mosi_seq", int'(mseq), int'(11'b00010100101));
    chk("wa_done_idx", d0, 12);
    chk("wa_done_idx_gap4", d1, 12);
    chk("wa_ss_low", sslow, 12);
    chk("wa_no_rv", nrv, 0);

    force_en = 1; force_val = 8'h3C;
    run_one(CMD_RD_DATA, 8'h00, -1, d0, d1, mseq, sslow, ndone, nrv);
    force_en = 0;
    chk("rd_done_idx", d0, 21);
    chk("rd_done_idx_gap4", d1, 23);
    chk("rd_ss_low", sslow, 21);
    chk("rd_data", int'(b0.rd_data), 8'h3C);
    chk("rd_data_gap4", int'(b1.rd_data), 8'h3C);
    chk("rd_rv_count", nrv, 1);

    run_one(CMD_WR_ADDR, 8'hA5, 4, d0, d1, mseq, sslow, ndone, nrv);
    chk("busy_mosi_seq", int'(mseq), int'(11'b00010100101));
    chk("busy_single_done", ndone, 1);
    chk("busy_done_idx", d0, 12);

    // Back-to-back: start held high, every ss_n high run must be one cycle.
    hrun = 0; gaps = 0; seen_low = 0;
    @(negedge clk); start = 1'b1; cmd = CMD_RD_ADDR; wdata = 8'h0F;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (b0.ss_n) hrun++;
      else begin
        if (seen_low && hrun > 0) begin chk("b2b_gap", hrun, 1); gaps++; end
        seen_low = 1; hrun = 0;
      end
    end
    start = 1'b0;
    chk("b2b_gaps_seen", int'(gaps >= 3), 1);
    repeat (30) @(negedge clk);

    // Reset in the middle of a read-data frame.
    @(negedge clk); start = 1'b1; cmd = CMD_RD_DATA;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("rst_mid_dut0", int'(got[0]), int'(13'b1_0_0_0_0_00000000));
    chk("rst_mid_dut1", int'(got[1]), int'(13'b1_0_0_0_0_00000000));
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    run_one(CMD_WR_ADDR, 8'hA5, -1, d0, d1, mseq, sslow, ndone, nrv);
    chk("post_rst_mosi_seq", int'(mseq), int'(11'b00010100101));
    chk("post_rst_done_idx", d0, 12);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 499) == 0) rst = 1'b1;
      start = ($urandom_range(0, 3) == 0);
      cmd   = 2'($urandom);
      wdata = 8'($urandom);
    end
    start = 1'b0; rst = 1'b0;
    repeat (40) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
